// File: rtl/ahb_lite_master.sv
// ahb_lite_master: turns one command/response request into AHB-Lite SINGLE/INCR transfers of 1..MAX_BEATS beats
//   HCLK, HRESETn : bus clock, asynchronous active-low reset
//   cmd_*         : command handshake (valid/ready) with direction, start address, size, beats-1, packed write data
//   rsp_*         : one pulse per completed beat carrying read data, last-beat and error flags
//   H*            : AHB-Lite master signals (registered address/control and write data)
module ahb_lite_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 4
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [ADDR_W-1:0]               cmd_addr,
  input  logic [2:0]                      cmd_size,
  input  logic [$clog2(MAX_BEATS)-1:0]    cmd_len,
  input  logic [MAX_BEATS*DATA_W-1:0]     cmd_wdata,
  output logic                            rsp_valid,
  output logic [DATA_W-1:0]               rsp_rdata,
  output logic                            rsp_last,
  output logic                            rsp_err,
  output logic [ADDR_W-1:0]               HADDR,
  output logic [1:0]                      HTRANS,
  output logic                            HWRITE,
  output logic [2:0]                      HSIZE,
  output logic [2:0]                      HBURST,
  output logic [DATA_W-1:0]               HWDATA,
  input  logic [DATA_W-1:0]               HRDATA,
  input  logic                            HREADY,
  input  logic                            HRESP
);
  localparam int LW = $clog2(MAX_BEATS);
  localparam logic [1:0] TR_IDLE = 2'b00, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11;
  typedef enum logic [2:0] {IDLE, ADDR, BURST, DATA, ERR} state_t;
  state_t state, state_n;
  logic [LW-1:0] len_q, abeat;
  logic [MAX_BEATS*DATA_W-1:0] wdata_q;
  logic accept, more, adone, dcomp;
  logic [ADDR_W-1:0] nxt_addr;
  logic [1:0] trans_n;
  assign cmd_ready = state == IDLE;
  // abeat is the beat currently in its address phase; the data phase always trails it by one.
  // An address phase in BURST is abandoned when the beat ahead of it reports an error.
  always_comb begin
    accept   = state == IDLE && cmd_valid;
    more     = abeat != len_q;
    adone    = (state == ADDR || (state == BURST && !HRESP)) && HREADY;
    dcomp    = (state == BURST || state == DATA || state == ERR) && HREADY;
    nxt_addr = HADDR + (ADDR_W'(1) << HSIZE);
    state_n  = state;
    case (state)
      IDLE:    state_n = cmd_valid ? ADDR : IDLE;
      ADDR:    state_n = HREADY ? (more ? BURST : DATA) : ADDR;
      BURST:   state_n = HRESP ? (HREADY ? IDLE : ERR) : (HREADY ? (more ? BURST : DATA) : BURST);
      DATA:    state_n = HREADY ? IDLE : (HRESP ? ERR : DATA);
      ERR:     state_n = HREADY ? IDLE : ERR;
      default: state_n = IDLE;
    endcase
    // a SEQ beat that wraps addr[9:0] to zero enters a new 1 KB region and must restart as NONSEQ
    trans_n = state_n == ADDR ? TR_NONSEQ :
              state_n == BURST ? (adone ? (nxt_addr[9:0] == 10'd0 ? TR_NONSEQ : TR_SEQ) : HTRANS) :
              TR_IDLE;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR     <= '0;
      HTRANS    <= TR_IDLE;
      HWRITE    <= 1'b0;
      HSIZE     <= 3'd0;
      HBURST    <= 3'd0;
      HWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      len_q     <= '0;
      abeat     <= '0;
      wdata_q   <= '0;
    end else begin
      HTRANS    <= trans_n;
      rsp_valid <= dcomp;
      rsp_err   <= dcomp && HRESP;
      rsp_last  <= dcomp && (HRESP || state != BURST);
      rsp_rdata <= dcomp && !HWRITE ? HRDATA : '0;
      if (accept) begin
        HADDR   <= cmd_addr;
        HWRITE  <= cmd_write;
        HSIZE   <= cmd_size > 3'd2 ? 3'd2 : cmd_size;
        HBURST  <= cmd_len == '0 ? 3'b000 : 3'b001;
        len_q   <= cmd_len;
        wdata_q <= cmd_wdata;
        abeat   <= '0;
      end
      if (adone) begin
        HWDATA <= HWRITE ? wdata_q[abeat*DATA_W +: DATA_W] : '0;
        if (more) begin
          HADDR <= nxt_addr;
          abeat <= abeat + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed cycle-by-cycle checks of ahb_lite_master against hand-computed bus/response values
module tb_ahb_lite_master;
  logic HCLK = 1'b0, HRESETn;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0] cmd_size = '0;
  logic [1:0] cmd_len = '0;
  logic [127:0] cmd_wdata = '0;
  logic rsp_valid, rsp_last, rsp_err;
  logic [31:0] rsp_rdata, HADDR, HWDATA, HRDATA = '0;
  logic [1:0] HTRANS;
  logic HWRITE, HREADY = 1'b1, HRESP = 1'b0;
  logic [2:0] HSIZE, HBURST;
  int n_vec = 0, n_err = 0;
  ahb_lite_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
    .rsp_err(rsp_err), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );
  always #5 HCLK = ~HCLK;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge HCLK);
  endtask
  task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [1:0] l, input logic [127:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_len = l; cmd_wdata = d;
    cyc();
    cmd_valid = 1'b0;
  endtask
  task automatic bus(input string tag, input logic [1:0] t, input logic [31:0] a);
    check({tag, "/htrans"}, HTRANS, t);
    check({tag, "/haddr"}, HADDR, a);
  endtask
  task automatic rsp(input string tag, input logic v, input logic l, input logic e);
    check({tag, "/rsp_valid"}, rsp_valid, v);
    check({tag, "/rsp_last"}, rsp_last, l);
    check({tag, "/rsp_err"}, rsp_err, e);
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    HRESETn = 1'b1;
    #1 HRESETn = 1'b0;
    cyc(); cyc();
    bus("rst", 2'b00, 32'h0);
    check("rst/hwrite", HWRITE, 1'b0);
    check("rst/hsize", HSIZE, 3'd0);
    check("rst/hburst", HBURST, 3'd0);
    check("rst/hwdata", HWDATA, 32'h0);
    check("rst/cmd_ready", cmd_ready, 1'b1);
    rsp("rst", 1'b0, 1'b0, 1'b0);
    check("rst/rsp_rdata", rsp_rdata, 32'h0);
    HRESETn = 1'b1;
    cyc();
    // single word write
    send(1'b1, 32'h10, 3'd2, 2'd0, 128'hA5A5_1234);
    bus("w1.a", 2'b10, 32'h10);
    check("w1/hwrite", HWRITE, 1'b1);
    check("w1/hsize", HSIZE, 3'd2);
    check("w1/hburst", HBURST, 3'd0);
    check("w1/cmd_ready", cmd_ready, 1'b0);
    cyc();
    check("w1.d/htrans", HTRANS, 2'b00);
    check("w1.d/hwdata", HWDATA, 32'hA5A5_1234);
    check("w1.d/rsp_valid", rsp_valid, 1'b0);
    cyc();
    rsp("w1.r", 1'b1, 1'b1, 1'b0);
    check("w1.r/rsp_rdata", rsp_rdata, 32'h0);
    check("w1.r/cmd_ready", cmd_ready, 1'b1);
    cyc();
    check("w1.e/rsp_valid", rsp_valid, 1'b0);
    // single halfword read with two wait states
    send(1'b0, 32'h20, 3'd1, 2'd0, 128'h0);
    bus("r1.a", 2'b10, 32'h20);
    check("r1/hsize", HSIZE, 3'd1);
    check("r1/hwrite", HWRITE, 1'b0);
    cyc();
    HREADY = 1'b0;
    check("r1.d/htrans", HTRANS, 2'b00);
    cyc();
    check("r1.w1/rsp_valid", rsp_valid, 1'b0);
    check("r1.w1/haddr", HADDR, 32'h20);
    check("r1.w1/hsize", HSIZE, 3'd1);
    cyc();
    check("r1.w2/rsp_valid", rsp_valid, 1'b0);
    HREADY = 1'b1; HRDATA = 32'h0000_BEEF;
    cyc();
    rsp("r1.r", 1'b1, 1'b1, 1'b0);
    check("r1.r/rsp_rdata", rsp_rdata, 32'h0000_BEEF);
    HRDATA = 32'h0;
    cyc();
    check("r1.e/rsp_valid", rsp_valid, 1'b0);
    // 4-beat word write with one wait state on beat 2
    send(1'b1, 32'h40, 3'd2, 2'd3, 128'h44444444_33333333_22222222_11111111);
    bus("w4.0", 2'b10, 32'h40);
    check("w4/hburst", HBURST, 3'b001);
    cyc();
    bus("w4.1", 2'b11, 32'h44);
    check("w4.1/hwdata", HWDATA, 32'h11111111);
    check("w4.1/rsp_valid", rsp_valid, 1'b0);
    cyc();
    bus("w4.2", 2'b11, 32'h48);
    check("w4.2/hwdata", HWDATA, 32'h22222222);
    rsp("w4.2", 1'b1, 1'b0, 1'b0);
    HREADY = 1'b0;
    cyc();
    bus("w4.2w", 2'b11, 32'h48);
    check("w4.2w/hwdata", HWDATA, 32'h22222222);
    check("w4.2w/rsp_valid", rsp_valid, 1'b0);
    HREADY = 1'b1;
    cyc();
    bus("w4.3", 2'b11, 32'h4C);
    check("w4.3/hwdata", HWDATA, 32'h33333333);
    rsp("w4.3", 1'b1, 1'b0, 1'b0);
    cyc();
    check("w4.4/htrans", HTRANS, 2'b00);
    check("w4.4/hwdata", HWDATA, 32'h44444444);
    rsp("w4.4", 1'b1, 1'b0, 1'b0);
    cyc();
    rsp("w4.r", 1'b1, 1'b1, 1'b0);
    check("w4.r/cmd_ready", cmd_ready, 1'b1);
    cyc();
    check("w4.e/rsp_valid", rsp_valid, 1'b0);
    // 4-beat byte read crossing a 1 KB boundary
    send(1'b0, 32'h3FE, 3'd0, 2'd3, 128'h0);
    bus("b4.0", 2'b10, 32'h3FE);
    check("b4/hsize", HSIZE, 3'd0);
    cyc();
    bus("b4.1", 2'b11, 32'h3FF);
    HRDATA = 32'h11;
    cyc();
    bus("b4.2", 2'b10, 32'h400);
    rsp("b4.r0", 1'b1, 1'b0, 1'b0);
    check("b4.r0/rdata", rsp_rdata, 32'h11);
    HRDATA = 32'h22;
    cyc();
    bus("b4.3", 2'b11, 32'h401);
    check("b4.r1/rdata", rsp_rdata, 32'h22);
    HRDATA = 32'h33;
    cyc();
    check("b4.d/htrans", HTRANS, 2'b00);
    check("b4.r2/rdata", rsp_rdata, 32'h33);
    HRDATA = 32'h44;
    cyc();
    rsp("b4.r3", 1'b1, 1'b1, 1'b0);
    check("b4.r3/rdata", rsp_rdata, 32'h44);
    HRDATA = 32'h0;
    cyc();
    // error on beat 2 of a 4-beat read
    send(1'b0, 32'h80, 3'd2, 2'd3, 128'h0);
    bus("e4.0", 2'b10, 32'h80);
    cyc();
    bus("e4.1", 2'b11, 32'h84);
    HRDATA = 32'hD0;
    cyc();
    bus("e4.2", 2'b11, 32'h88);
    rsp("e4.r0", 1'b1, 1'b0, 1'b0);
    check("e4.r0/rdata", rsp_rdata, 32'hD0);
    HRDATA = 32'h0; HRESP = 1'b1; HREADY = 1'b0;
    cyc();
    check("e4.err2/htrans", HTRANS, 2'b00);
    check("e4.err2/rsp_valid", rsp_valid, 1'b0);
    check("e4.err2/cmd_ready", cmd_ready, 1'b0);
    HREADY = 1'b1;
    cyc();
    rsp("e4.r1", 1'b1, 1'b1, 1'b1);
    check("e4.r1/cmd_ready", cmd_ready, 1'b1);
    check("e4.r1/htrans", HTRANS, 2'b00);
    HRESP = 1'b0;
    cyc();
    check("e4.e/htrans", HTRANS, 2'b00);
    check("e4.e/rsp_valid", rsp_valid, 1'b0);
    // asynchronous reset during beat 3, then a fresh command with oversize cmd_size
    send(1'b1, 32'h100, 3'd2, 2'd3, 128'hDDDD_CCCC_BBBB_AAAA);
    bus("x.0", 2'b10, 32'h100);
    cyc();
    bus("x.1", 2'b11, 32'h104);
    cyc();
    bus("x.2", 2'b11, 32'h108);
    #2 HRESETn = 1'b0;
    #1;
    bus("x.rst", 2'b00, 32'h0);
    check("x.rst/hwdata", HWDATA, 32'h0);
    check("x.rst/hwrite", HWRITE, 1'b0);
    check("x.rst/hsize", HSIZE, 3'd0);
    check("x.rst/hburst", HBURST, 3'd0);
    check("x.rst/cmd_ready", cmd_ready, 1'b1);
    rsp("x.rst", 1'b0, 1'b0, 1'b0);
    cyc();
    check("x.rst2/rsp_valid", rsp_valid, 1'b0);
    HRESETn = 1'b1;
    cyc();
    check("x.idle/rsp_valid", rsp_valid, 1'b0);
    send(1'b0, 32'h200, 3'd3, 2'd0, 128'h0);
    bus("f.a", 2'b10, 32'h200);
    check("f/hsize_clamp", HSIZE, 3'd2);
    cyc();
    HRDATA = 32'h1234_5678;
    check("f.d/htrans", HTRANS, 2'b00);
    cyc();
    rsp("f.r", 1'b1, 1'b1, 1'b0);
    check("f.r/rdata", rsp_rdata, 32'h1234_5678);
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
